best_neighbor_scan: RTL and testbench
=====================================

// Module: best_neighbor_scan
// PURPOSE
//  Upstream stage of winnerPolicy. On start, scans the neighbour table in the shared 2048x8 byte memory.
//  Produces mybest, besthop, bestvalue and bestneighborID for winnerPolicy.
//  Writes the better-neighbour list and its count to memory; winnerPolicy's explore path reads them back.
//  Values are 16-bit costs, 11.5 fixed point; lower is better.
// PARAMETERS
//  NBR_COUNT_ADDR    16'h600  word holding the number of table entries
//  NBR_ID_BASE       16'h602  neighbour ID i at NBR_ID_BASE+2*i
//  NBR_VAL_BASE      16'h622  neighbour cost i at NBR_VAL_BASE+2*i
//  MYBEST_ADDR       16'h642  own current best cost
//  BETTER_BASE       16'h668  better-neighbour list, entry k at BETTER_BASE+2*k
//  BETTER_COUNT_ADDR 16'h68C  better-neighbour count word
//  MAX_NEIGHBORS     16       table length clamp
//  MAX_BETTER        18       list capacity: (BETTER_COUNT_ADDR-BETTER_BASE)/2
// PORTS
//  clock           in   1   sole clock, rising edge
//  nrst            in   1   asynchronous active-low reset
//  start_scan      in   1   level request; sampled only in IDLE
//  MY_NODE_ID      in   16  own node ID
//  data_in         in   16  memory read data, valid the cycle after address changes
//  address         out  16  memory byte address (registered)
//  data_out        out  16  memory write data (registered)
//  wr_en           out  1   memory write strobe, one cycle per write
//  mybest          out  16  own cost latched from MYBEST_ADDR
//  besthop         out  16  ID of lowest-cost neighbour; 100 (= -1) if none
//  bestvalue       out  16  lowest neighbour cost; 16'hFFFF if none
//  bestneighborID  out  16  besthop if bestvalue<mybest, else MY_NODE_ID
//  betterNeighborCount out 16 entries written to the list
//  done_scan       out  1   results valid; held until start_scan drops
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, wr_en=0, done_scan=0, address=0, data_out=0, mybest=0,
//   besthop=100, bestvalue=16'hFFFF, bestneighborID=0, betterNeighborCount=0. An in-flight write is dropped.
//  Registered-address read model: data_in is sampled in the state after the one that set address.
//  IDLE:   on start_scan, address<=NBR_COUNT_ADDR; clear best/count -> CNT.
//  CNT:    n<=min(data_in,MAX_NEIGHBORS); address<=MYBEST_ADDR -> MYB.
//  MYB:    mybest<=data_in; idx<=0. If n==0 -> WRCNT; else address<=NBR_ID_BASE -> ID.
//  ID:     id_tmp<=data_in; address<=NBR_VAL_BASE+2*idx -> VAL.
//  VAL:    If data_in<bestvalue (strict; first minimum wins on ties): bestvalue<=data_in, besthop<=id_tmp.
//          If data_in<mybest and count<MAX_BETTER: address<=BETTER_BASE+2*count, data_out<=id_tmp,
//           wr_en<=1, count++ -> WR.
//          Better neighbour with list full: silently not recorded. Else -> NEXT.
//  WR:     wr_en<=0 -> NEXT.
//  NEXT:   If idx==n-1 -> WRCNT; else idx++, address<=NBR_ID_BASE+2*(idx+1) -> ID.
//  WRCNT:  address<=BETTER_COUNT_ADDR, data_out<=count, wr_en<=1 -> FIN.
//  FIN:    wr_en<=0; bestneighborID resolved; done_scan<=1 -> DONE.
//  DONE:   hold all outputs; when start_scan==0, done_scan<=0 -> IDLE. A held start never re-triggers.
//  Latency: done_scan rises 5+3n+w edges after start is sampled (w = list writes).
//  Address arithmetic is 16-bit unsigned, no wrap within the map. Comparisons are unsigned 16-bit.
//  start_scan outside IDLE is ignored. Outputs remain stable from FIN until next start.
// STRUCTURE
//  Address-map constants and the NO_HOP=100 sentinel live in the shared routing constants package.
//  winnerPolicy uses the same package (0x668/0x68C).
//  Single flat FSM; no sub-module. The 4-bit state encoding is a local constant set.
// TESTING
//  1 n=0, mybest=0x0140 -> done after 5 edges; besthop=100, bestvalue=FFFF, bestneighborID=MY_NODE_ID;
//    mem[0x68C]=0.
//  2 n=3, IDs {5,7,9}, costs {0x0200,0x00A0,0x0300}, mybest=0x0100 -> besthop=7, bestvalue=0x00A0,
//    bestneighborID=7, list {7}, count=1.
//  3 Tie: costs {0x0080,0x0080}, IDs {3,4}, mybest=0x0100 -> besthop=3; list {3,4}; count=2.
//  4 n=20 (clamped to 16), all costs 0 < mybest -> 16 writes; count=16; n=MAX_BETTER+ case -> no write
//    past 0x68A.
//  5 All costs >= mybest=0x0050 -> count=0; bestneighborID=MY_NODE_ID; no list writes.
//  6 Assert nrst low during WR -> wr_en drops at once; all outputs at reset values; new start rescans cleanly.

Source files
------------

// File: rtl/best_neighbor_scan_pkg.sv
// Purpose : shared routing constants (neighbour-table address map, sentinels) and scan FSM encoding.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package best_neighbor_scan_pkg;

    typedef logic [15:0] word_t;

    // Neighbour table and better-list map in the shared 2048x8 byte memory.
    // winnerPolicy reads BETTER_BASE / BETTER_COUNT_ADDR back on its explore path.
    localparam word_t NBR_COUNT_ADDR    = 16'h0600;
    localparam word_t NBR_ID_BASE       = 16'h0602;
    localparam word_t NBR_VAL_BASE      = 16'h0622;
    localparam word_t MYBEST_ADDR       = 16'h0642;
    localparam word_t BETTER_BASE       = 16'h0668;
    localparam word_t BETTER_COUNT_ADDR = 16'h068C;

    // Table length clamp and list capacity ((0x68C-0x668)/2).
    localparam logic [4:0] MAX_NEIGHBORS = 5'd16;
    localparam logic [4:0] MAX_BETTER    = 5'd18;

    // "No hop" sentinel (stands for -1 in winnerPolicy) and the empty best cost.
    localparam word_t NO_HOP     = 16'd100;
    localparam word_t COST_EMPTY = 16'hFFFF;

    // Scan FSM encoding, 4 bits.
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CNT   = 4'd1,
        S_MYB   = 4'd2,
        S_ID    = 4'd3,
        S_VAL   = 4'd4,
        S_WR    = 4'd5,
        S_NEXT  = 4'd6,
        S_WRCNT = 4'd7,
        S_FIN   = 4'd8,
        S_DONE  = 4'd9
    } scan_state_e;

    // Byte address of 16-bit entry idx in a table starting at base.
    function automatic word_t word_addr(input word_t base, input logic [4:0] idx);
        return base + {10'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/best_neighbor_scan_if.sv
// Purpose : bundle of the scanner's memory bus, control and result signals.
// Latency : n/a (wires only).
// Backpressure: none; memory is assumed always ready, start_scan is a level request.
// master = scanner side, slave = memory / winnerPolicy side.
interface best_neighbor_scan_if;
    import best_neighbor_scan_pkg::*;

    logic  start_scan;
    word_t MY_NODE_ID;
    word_t data_in;
    word_t address;
    word_t data_out;
    logic  wr_en;
    word_t mybest;
    word_t besthop;
    word_t bestvalue;
    word_t bestneighborID;
    word_t betterNeighborCount;
    logic  done_scan;

    modport master (
        input  start_scan, MY_NODE_ID, data_in,
        output address, data_out, wr_en,
        output mybest, besthop, bestvalue, bestneighborID, betterNeighborCount, done_scan
    );

    modport slave (
        output start_scan, MY_NODE_ID, data_in,
        input  address, data_out, wr_en,
        input  mybest, besthop, bestvalue, bestneighborID, betterNeighborCount, done_scan
    );

endinterface

// File: rtl/best_neighbor_scan.sv
// Purpose : scan the neighbour table, find the lowest-cost hop, write the better-neighbour list + count.
// Latency : done_scan rises 5+3n+w clock edges after start_scan is sampled (n entries, w list writes).
// Backpressure: none; one memory access per state, results held in DONE until start_scan drops.
// Ports: clock, nrst (async active-low); bus (master modport) carries start_scan, MY_NODE_ID,
//        data_in, registered address/data_out/wr_en and the registered result outputs.
module best_neighbor_scan
    import best_neighbor_scan_pkg::*;
(
    input  logic                clock,
    input  logic                nrst,
    best_neighbor_scan_if.master bus
);

    scan_state_e state_q, state_d;

    word_t      address_q,   address_d;
    word_t      data_out_q,  data_out_d;
    logic       wr_en_q,     wr_en_d;
    word_t      mybest_q,    mybest_d;
    word_t      besthop_q,   besthop_d;
    word_t      bestvalue_q, bestvalue_d;
    word_t      bestnbr_q,   bestnbr_d;
    logic [4:0] count_q,     count_d;
    logic [4:0] n_q,         n_d;
    logic [4:0] idx_q,       idx_d;
    word_t      id_tmp_q,    id_tmp_d;
    logic       done_q,      done_d;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            address_q   <= '0;
            data_out_q  <= '0;
            wr_en_q     <= 1'b0;
            mybest_q    <= '0;
            besthop_q   <= NO_HOP;
            bestvalue_q <= COST_EMPTY;
            bestnbr_q   <= '0;
            count_q     <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            id_tmp_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            data_out_q  <= data_out_d;
            wr_en_q     <= wr_en_d;
            mybest_q    <= mybest_d;
            besthop_q   <= besthop_d;
            bestvalue_q <= bestvalue_d;
            bestnbr_q   <= bestnbr_d;
            count_q     <= count_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            id_tmp_q    <= id_tmp_d;
            done_q      <= done_d;
        end
    end

    // Reads are registered-address: each state consumes data_in for the address
    // the previous state put on the bus.
    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        data_out_d  = data_out_q;
        wr_en_d     = wr_en_q;
        mybest_d    = mybest_q;
        besthop_d   = besthop_q;
        bestvalue_d = bestvalue_q;
        bestnbr_d   = bestnbr_q;
        count_d     = count_q;
        n_d         = n_q;
        idx_d       = idx_q;
        id_tmp_d    = id_tmp_q;
        done_d      = done_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_scan) begin
                    address_d   = NBR_COUNT_ADDR;
                    bestvalue_d = COST_EMPTY;
                    besthop_d   = NO_HOP;
                    count_d     = '0;
                    state_d     = S_CNT;
                end
            end
            S_CNT: begin
                // Oversized tables are clamped so the ID/cost regions are never overrun.
                n_d       = (bus.data_in > {11'd0, MAX_NEIGHBORS}) ? MAX_NEIGHBORS : bus.data_in[4:0];
                address_d = MYBEST_ADDR;
                state_d   = S_MYB;
            end
            S_MYB: begin
                mybest_d = bus.data_in;
                idx_d    = '0;
                if (n_q == 5'd0) begin
                    state_d = S_WRCNT;
                end else begin
                    address_d = NBR_ID_BASE;
                    state_d   = S_ID;
                end
            end
            S_ID: begin
                id_tmp_d  = bus.data_in;
                address_d = word_addr(NBR_VAL_BASE, idx_q);
                state_d   = S_VAL;
            end
            S_VAL: begin
                // Strict compare: on equal costs the earliest entry keeps the hop.
                if (bus.data_in < bestvalue_q) begin
                    bestvalue_d = bus.data_in;
                    besthop_d   = id_tmp_q;
                end
                // A better neighbour found once the list is full is dropped silently.
                if ((bus.data_in < mybest_q) && (count_q < MAX_BETTER)) begin
                    address_d  = word_addr(BETTER_BASE, count_q);
                    data_out_d = id_tmp_q;
                    wr_en_d    = 1'b1;
                    count_d    = count_q + 5'd1;
                    state_d    = S_WR;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WR: begin
                wr_en_d = 1'b0;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                // n_q >= 1 here, so n_q-1 cannot underflow.
                if (idx_q == n_q - 5'd1) begin
                    state_d = S_WRCNT;
                end else begin
                    idx_d     = idx_q + 5'd1;
                    address_d = word_addr(NBR_ID_BASE, idx_q + 5'd1);
                    state_d   = S_ID;
                end
            end
            S_WRCNT: begin
                address_d  = BETTER_COUNT_ADDR;
                data_out_d = {11'd0, count_q};
                wr_en_d    = 1'b1;
                state_d    = S_FIN;
            end
            S_FIN: begin
                wr_en_d   = 1'b0;
                // Only route away from ourselves when a neighbour strictly beats our own cost.
                bestnbr_d = (bestvalue_q < mybest_q) ? besthop_q : bus.MY_NODE_ID;
                done_d    = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                // Requires start_scan to drop, so a held request never rescans.
                if (!bus.start_scan) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.address             = address_q;
    assign bus.data_out            = data_out_q;
    assign bus.wr_en               = wr_en_q;
    assign bus.mybest              = mybest_q;
    assign bus.besthop             = besthop_q;
    assign bus.bestvalue           = bestvalue_q;
    assign bus.bestneighborID      = bestnbr_q;
    assign bus.betterNeighborCount = {11'd0, count_q};
    assign bus.done_scan           = done_q;

endmodule

// File: tb/tb_best_neighbor_scan.sv
// Purpose : self-checking bench for best_neighbor_scan with a word memory model and result/write scoreboards.
// Latency : n/a.
// Backpressure: n/a.
module tb_best_neighbor_scan;
    import best_neighbor_scan_pkg::*;

    logic clock = 1'b0;
    logic nrst  = 1'b0;
    always #5 clock = ~clock;

    best_neighbor_scan_if bus();

    best_neighbor_scan dut (
        .clock (clock),
        .nrst  (nrst),
        .bus   (bus)
    );

    // Memory: mem is loaded by the stimulus, wmem captures DUT writes.
    logic [15:0] mem  [0:1023];
    logic [15:0] wmem [0:1023];

    function automatic logic [9:0] widx(input logic [15:0] a);
        return a[10:1];
    endfunction

    assign bus.data_in = mem[widx(bus.address)];

    always @(posedge clock) begin
        if (bus.wr_en) wmem[widx(bus.address)] <= bus.data_out;
    end

    typedef struct packed {
        logic [15:0] besthop;
        logic [15:0] bestvalue;
        logic [15:0] bnid;
        logic [15:0] mybest;
        logic [15:0] count;
        logic [15:0] lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_wr_q[$];   // {address, data}

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the next expected write.
    always @(negedge clock) begin
        if (nrst && bus.wr_en) begin
            check("wr_in_map", {31'd0, (bus.address <= 16'h068C)}, 32'd1);
            if (exp_wr_q.size() == 0) begin
                check("wr_unexpected", exp_wr_q.size(), 32'd1);
            end else begin
                check("wr_addr_data", {bus.address, bus.data_out}, exp_wr_q.pop_front());
            end
        end
    end

    logic [15:0] ids   [0:19];
    logic [15:0] costs [0:19];

    // Load the table and push the reference results.
    task automatic prep_scan(input int n_raw, input logic [15:0] myb, input logic [15:0] myid);
        int   n;
        int   cnt;
        exp_t e;
        mem[widx(16'h0600)] = 16'(n_raw);
        for (int i = 0; i < 16; i++) begin
            mem[widx(16'h0602 + 16'(2 * i))] = ids[i];
            mem[widx(16'h0622 + 16'(2 * i))] = costs[i];
        end
        mem[widx(16'h0642)] = myb;
        bus.MY_NODE_ID = myid;

        n           = (n_raw > 16) ? 16 : n_raw;
        cnt         = 0;
        e.besthop   = 16'd100;
        e.bestvalue = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            if (costs[i] < e.bestvalue) begin
                e.bestvalue = costs[i];
                e.besthop   = ids[i];
            end
            if (costs[i] < myb && cnt < 18) begin
                exp_wr_q.push_back({16'h0668 + 16'(2 * cnt), ids[i]});
                cnt++;
            end
        end
        exp_wr_q.push_back({16'h068C, 16'(cnt)});
        e.bnid   = (e.bestvalue < myb) ? e.besthop : myid;
        e.mybest = myb;
        e.count  = 16'(cnt);
        e.lat    = 16'(5 + 3 * n + cnt);
        exp_q.push_back(e);
    endtask

    // Raise start, wait for done (bounded), compare, check hold, then release.
    task automatic finish_scan();
        int   edges;
        bit   got;
        exp_t e;
        edges = 0;
        got   = 1'b0;
        @(negedge clock);
        bus.start_scan = 1'b1;
        while (!got && edges < 400) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            got = bus.done_scan;
        end
        check("done_seen", {31'd0, bus.done_scan}, 32'd1);
        e = exp_q.pop_front();
        check("latency",    edges,                   {16'd0, e.lat});
        check("besthop",    bus.besthop,             {16'd0, e.besthop});
        check("bestvalue",  bus.bestvalue,           {16'd0, e.bestvalue});
        check("bestnbr_id", bus.bestneighborID,      {16'd0, e.bnid});
        check("mybest",     bus.mybest,              {16'd0, e.mybest});
        check("better_cnt", bus.betterNeighborCount, {16'd0, e.count});
        check("cnt_word",   wmem[widx(16'h068C)],    {16'd0, e.count});
        check("wr_pending", exp_wr_q.size(),         32'd0);
        repeat (3) @(negedge clock);
        check("done_hold",  {31'd0, bus.done_scan},  32'd1);
        check("hop_hold",   bus.besthop,             {16'd0, e.besthop});
        bus.start_scan = 1'b0;
        @(negedge clock);
        check("done_drop",  {31'd0, bus.done_scan},  32'd0);
        @(negedge clock);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_wr_en"},   {31'd0, bus.wr_en},       32'd0);
        check({pfx, "_address"}, bus.address,              32'd0);
        check({pfx, "_data_out"}, bus.data_out,            32'd0);
        check({pfx, "_mybest"},  bus.mybest,               32'd0);
        check({pfx, "_besthop"}, bus.besthop,              32'd100);
        check({pfx, "_bestval"}, bus.bestvalue,            32'h0000FFFF);
        check({pfx, "_bnid"},    bus.bestneighborID,       32'd0);
        check({pfx, "_count"},   bus.betterNeighborCount,  32'd0);
        check({pfx, "_done"},    {31'd0, bus.done_scan},   32'd0);
    endtask

    task automatic clear_table();
        for (int i = 0; i < 20; i++) begin
            ids[i]   = 16'd0;
            costs[i] = 16'd0;
        end
    endtask

    initial begin
        int edges;
        for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
        bus.start_scan = 1'b0;
        bus.MY_NODE_ID = 16'd0;
        clear_table();

        #12;
        check_reset_vals("rst");
        @(negedge clock);
        nrst = 1'b1;
        @(negedge clock);

        // 1: empty table.
        prep_scan(0, 16'h0140, 16'h0011);
        finish_scan();

        // 2: one better neighbour among three.
        clear_table();
        ids[0] = 16'd5; ids[1] = 16'd7; ids[2] = 16'd9;
        costs[0] = 16'h0200; costs[1] = 16'h00A0; costs[2] = 16'h0300;
        prep_scan(3, 16'h0100, 16'h0022);
        finish_scan();

        // 3: tie, first minimum keeps the hop.
        clear_table();
        ids[0] = 16'd3; ids[1] = 16'd4;
        costs[0] = 16'h0080; costs[1] = 16'h0080;
        prep_scan(2, 16'h0100, 16'h0033);
        finish_scan();

        // 4: oversized table clamps to 16, every entry better.
        clear_table();
        for (int i = 0; i < 20; i++) ids[i] = 16'(40 + i);
        prep_scan(20, 16'h0100, 16'h0044);
        finish_scan();

        // 5: nothing beats our own cost (equal is not better).
        clear_table();
        ids[0] = 16'd21; ids[1] = 16'd22; ids[2] = 16'd23;
        costs[0] = 16'h0050; costs[1] = 16'h0060; costs[2] = 16'h0100;
        prep_scan(3, 16'h0050, 16'h0055);
        finish_scan();

        // Random tables.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 20; i++) begin
                ids[i]   = 16'($urandom_range(1, 99));
                costs[i] = 16'($urandom_range(0, 16'h0200));
            end
            prep_scan(int'($urandom_range(0, 18)), 16'($urandom_range(1, 16'h0200)), 16'($urandom_range(1, 99)));
            finish_scan();
        end

        // 6: reset while a list write is on the bus.
        clear_table();
        ids[0] = 16'd5; ids[1] = 16'd7; ids[2] = 16'd9;
        costs[0] = 16'h0200; costs[1] = 16'h00A0; costs[2] = 16'h0300;
        prep_scan(3, 16'h0100, 16'h0066);
        @(negedge clock);
        bus.start_scan = 1'b1;
        edges = 0;
        while (!bus.wr_en && edges < 100) begin
            @(negedge clock);
            edges++;
        end
        check("wr_reached", {31'd0, bus.wr_en}, 32'd1);
        #2;
        nrst = 1'b0;
        bus.start_scan = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        exp_wr_q.delete();
        repeat (2) @(negedge clock);
        check("rst_hold_wr", {31'd0, bus.wr_en}, 32'd0);
        nrst = 1'b1;
        @(negedge clock);
        prep_scan(3, 16'h0100, 16'h0066);
        finish_scan();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
